// File: rtl/mmio_led_ctrl.sv
// mmio_led_ctrl: memory-mapped LED controller on the data-memory bus.
// Each channel is driven directly, by PWM, by blinking or by inverted PWM.
// A shared prescaler sets the PWM time base. Duty values pass through a shadow
// register so that a new duty only takes effect on a PWM period boundary.
module mmio_led_ctrl #(
    parameter int          NUM_LED    = 8,
    parameter int          PWM_BITS   = 8,
    parameter int          PRESC_BITS = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [31:0]        a,
    input  logic [31:0]        wd,
    output logic [31:0]        rd,
    output logic               hit,
    output logic [NUM_LED-1:0] led
);

    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
    localparam int                  MODE_W  = 2 * NUM_LED;

    logic [3:0]            off;
    logic                  wr;
    logic                  prst;
    logic                  tick;
    logic                  wrap;
    logic                  load_shadow;

    logic                  en;
    logic [PRESC_BITS-1:0] presc;
    logic [NUM_LED-1:0]    direct;
    logic [MODE_W-1:0]     mode;
    logic [7:0]            blink;
    logic [PWM_BITS-1:0]   duty    [NUM_LED];
    logic [PWM_BITS-1:0]   dshadow [NUM_LED];

    logic [PRESC_BITS-1:0] presc_cnt;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [7:0]            blink_cnt;
    logic                  blink_phase;
    logic [NUM_LED-1:0]    led_nxt;

    // Byte-lane bits of the address and the high data bits have no function here.
    logic                  unused_bits;

    assign off         = a[5:2];
    assign hit         = (a[31:6] == BASE_ADDR[31:6]);
    assign wr          = we && hit;
    assign prst        = wr && (off == 4'h0) && wd[1];
    // The >= compare means lowering PRESC below presc_cnt ticks on the next cycle.
    assign tick        = en && (presc_cnt >= presc);
    assign wrap        = tick && (pwm_cnt == PWM_MAX);
    // A PRST pulse restarts the period, so it also suppresses the boundary load.
    assign load_shadow = !en || (wrap && !prst);
    assign unused_bits = ^{a[1:0], wd};

    // Software-visible registers, written when the bus strobes this window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en     <= 1'b0;
            presc  <= '0;
            direct <= '0;
            mode   <= '0;
            blink  <= '0;
            for (int i = 0; i < NUM_LED; i++) duty[i] <= '0;
        end else if (wr) begin
            case (off)
                4'h0:    en     <= wd[0];
                4'h1:    presc  <= wd[PRESC_BITS-1:0];
                4'h2:    direct <= wd[NUM_LED-1:0];
                4'h3:    mode   <= wd[MODE_W-1:0];
                4'h4:    blink  <= wd[7:0];
                default: ;
            endcase
            for (int i = 0; i < NUM_LED; i++) begin
                if (off == 4'(8 + i)) duty[i] <= wd[PWM_BITS-1:0];
            end
        end
    end

    // Prescaler, PWM counter and blink state; held at zero while disabled or on PRST.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_cnt   <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (prst || !en) begin
            presc_cnt   <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (tick) begin
                presc_cnt <= '0;
                pwm_cnt   <= pwm_cnt + 1'b1;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
            if (wrap) begin
                if (blink_cnt == blink) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // Duty shadows track DUTY while disabled, otherwise reload only at period end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LED; i++) dshadow[i] <= '0;
        end else if (load_shadow) begin
            for (int i = 0; i < NUM_LED; i++) dshadow[i] <= duty[i];
        end
    end

    // Per-channel output selection; a disabled controller shows DIRECT.
    always_comb begin
        led_nxt = direct;
        if (en) begin
            for (int i = 0; i < NUM_LED; i++) begin
                case (mode[2*i +: 2])
                    2'b00:   led_nxt[i] = direct[i];
                    2'b01:   led_nxt[i] = (pwm_cnt < dshadow[i]);
                    2'b10:   led_nxt[i] = direct[i] & blink_phase;
                    default: led_nxt[i] = !(pwm_cnt < dshadow[i]);
                endcase
            end
        end
    end

    // LED output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) led <= '0;
        else        led <= led_nxt;
    end

    // Zero-latency read mux; PRST is write-only and unlisted offsets read 0.
    always_comb begin
        rd = '0;
        if (hit) begin
            case (off)
                4'h0:    rd = {31'b0, en};
                4'h1:    rd = 32'(presc);
                4'h2:    rd = 32'(direct);
                4'h3:    rd = 32'(mode);
                4'h4:    rd = {24'b0, blink};
                default: begin
                    for (int i = 0; i < NUM_LED; i++) begin
                        if (off == 4'(8 + i)) rd = 32'(duty[i]);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_led_ctrl.sv
// Testbench for mmio_led_ctrl: directed bus programs, a cycle-count based
// reference model compared against led every cycle, and literal checks of
// readback, PWM high counts and blink timing.
module tb_mmio_led_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        hit;
    logic [7:0]  led;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    mmio_led_ctrl #(
        .NUM_LED(8), .PWM_BITS(8), .PRESC_BITS(16), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd),
        .rd(rd), .hit(hit), .led(led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Counting is tracked as k = enabled cycles since the last restart;
    // prescaler, PWM position and blink phase follow from division.
    bit          m_en;
    int          m_presc;
    int          m_blink;
    logic [7:0]  m_direct;
    logic [15:0] m_mode;
    int          m_duty   [8];
    int          m_shadow [8];
    longint      m_k;
    logic [7:0]  m_led;

    always @(posedge clk or negedge reset) begin : model_p
        longint     ticks;
        longint     per_len;
        int         pos;
        int         phase;
        int         offm;
        bit         hit_m;
        bit         prst_m;
        logic [7:0] nxt;
        if (!reset) begin
            m_en     <= 1'b0;
            m_presc  <= 0;
            m_blink  <= 0;
            m_direct <= '0;
            m_mode   <= '0;
            m_k      <= 0;
            m_led    <= '0;
            for (int i = 0; i < 8; i++) begin
                m_duty[i]   <= 0;
                m_shadow[i] <= 0;
            end
        end else begin
            per_len = longint'(m_presc + 1) * 256;
            ticks   = m_k / longint'(m_presc + 1);
            pos     = int'(ticks % 256);
            phase   = int'((ticks / 256 / longint'(m_blink + 1)) % 2);
            nxt     = m_direct;
            if (m_en) begin
                for (int i = 0; i < 8; i++) begin
                    case (m_mode[2*i +: 2])
                        2'b00:   nxt[i] = m_direct[i];
                        2'b01:   nxt[i] = (pos < m_shadow[i]);
                        2'b10:   nxt[i] = m_direct[i] & (phase == 1);
                        default: nxt[i] = !(pos < m_shadow[i]);
                    endcase
                end
            end
            m_led <= nxt;
            hit_m  = (a[31:6] == BASE[31:6]);
            offm   = int'(a[5:2]);
            prst_m = we && hit_m && (offm == 0) && wd[1];
            if (!m_en || (!prst_m && ((m_k + 1) % per_len == 0))) begin
                for (int i = 0; i < 8; i++) m_shadow[i] <= m_duty[i];
            end
            if (prst_m || !m_en) m_k <= 0;
            else                 m_k <= m_k + 1;
            if (we && hit_m) begin
                case (offm)
                    0: m_en     <= wd[0];
                    1: m_presc  <= int'(wd[15:0]);
                    2: m_direct <= wd[7:0];
                    3: m_mode   <= wd[15:0];
                    4: m_blink  <= int'(wd[7:0]);
                    default: if (offm >= 8) m_duty[offm-8] <= int'(wd[7:0]);
                endcase
            end
        end
    end

    // Every-cycle comparison of led against the model.
    always @(negedge clk) begin
        if (chk_en) check("led_model", 32'(led), 32'(m_led));
    end

    // ---------------- bus helpers ----------------
    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        we = 1'b1; a = addr; wd = data;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd_chk(input logic [31:0] addr, input logic [31:0] exp, input string nm);
        @(negedge clk);
        a = addr;
        #1;
        check(nm, rd, exp);
    endtask

    task automatic hit_chk(input logic [31:0] addr, input logic exp, input string nm);
        @(negedge clk);
        a = addr;
        #1;
        check(nm, 32'(hit), 32'(exp));
    endtask

    task automatic wait_level(input int ch, input logic lvl, input int maxc, input string nm);
        int n;
        n = 0;
        while (led[ch] !== lvl) begin
            @(negedge clk);
            n++;
            if (n > maxc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s: led[%0d] never reached %0b within %0d cycles", nm, ch, lvl, maxc);
                return;
            end
        end
    endtask

    task automatic run_len(input int ch, input logic lvl, output int n);
        n = 0;
        while (led[ch] === lvl && n < 10000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_high(input int cycles, output int c0, output int c1, output int c2);
        c0 = 0; c1 = 0; c2 = 0;
        for (int i = 0; i < cycles; i++) begin
            if (led[0]) c0++;
            if (led[1]) c1++;
            if (led[2]) c2++;
            @(negedge clk);
        end
    endtask

    task automatic async_pulse(input bit do_check);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 if (do_check) check("led_async_clear", 32'(led), 32'h0);
        #2 reset = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int c0, c1, c2, cnt_a, cnt_b, n;
        reset = 1'b0; we = 1'b0; a = BASE; wd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        chk_en = 1'b1;

        // Reset readback
        for (int o = 0; o < 16; o++) rd_chk(BASE + 32'(4 * o), 32'h0, "rst_read");
        check("rst_led", 32'(led), 32'h0);

        // All-ones writes read back masked
        for (int o = 0; o < 16; o++) bus_wr(BASE + 32'(4 * o), 32'hFFFF_FFFF);
        rd_chk(BASE + 32'h00, 32'h0000_0001, "ctrl_mask");
        rd_chk(BASE + 32'h04, 32'h0000_FFFF, "presc_mask");
        rd_chk(BASE + 32'h08, 32'h0000_00FF, "direct_mask");
        rd_chk(BASE + 32'h0C, 32'h0000_FFFF, "mode_mask");
        rd_chk(BASE + 32'h10, 32'h0000_00FF, "blink_mask");
        rd_chk(BASE + 32'h14, 32'h0000_0000, "unlisted_14");
        rd_chk(BASE + 32'h1C, 32'h0000_0000, "unlisted_1c");
        rd_chk(BASE + 32'h20, 32'h0000_00FF, "duty0_mask");
        rd_chk(BASE + 32'h3C, 32'h0000_00FF, "duty7_mask");
        async_pulse(1'b0);

        // Direct mode and address decode
        hit_chk(32'h0000_0200, 1'b0, "hit_0x200");
        hit_chk(32'h0000_0100, 1'b1, "hit_0x100");
        hit_chk(32'h0000_013C, 1'b1, "hit_0x13c");
        hit_chk(32'h0000_0140, 1'b0, "hit_0x140");
        hit_chk(32'h0000_00FC, 1'b0, "hit_0x0fc");
        bus_wr(BASE + 32'h08, 32'h0000_00A5);
        check("direct_edge_n", 32'(led), 32'h0);
        @(negedge clk);
        check("direct_edge_n1", 32'(led), 32'hA5);
        bus_wr(BASE + 32'h00, 32'h1);
        repeat (10) @(negedge clk);
        check("direct_enabled", 32'(led), 32'hA5);
        async_pulse(1'b0);

        // PWM: duty 64 with PRESC=0
        bus_wr(BASE + 32'h04, 32'h0);
        bus_wr(BASE + 32'h20, 32'd64);
        bus_wr(BASE + 32'h0C, 32'h1);
        bus_wr(BASE + 32'h00, 32'h1);
        repeat (300) @(negedge clk);
        count_high(256, c0, c1, c2);
        check("pwm64_window", 32'(c0), 32'd64);

        // Duty change mid-period applies from the next period
        wait_level(0, 1'b0, 300, "pwm_align_low");
        wait_level(0, 1'b1, 300, "pwm_align_high");
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 512; i++) begin
            if (led[0]) begin
                if (i < 256) cnt_a++;
                else         cnt_b++;
            end
            if (i == 10) begin we = 1'b1; a = BASE + 32'h20; wd = 32'd192; end
            if (i == 11) we = 1'b0;
            @(negedge clk);
        end
        check("pwm_cur_period", 32'(cnt_a), 32'd64);
        check("pwm_next_period", 32'(cnt_b), 32'd192);

        // Duty bounds and inverted PWM
        bus_wr(BASE + 32'h24, 32'd0);
        bus_wr(BASE + 32'h28, 32'd255);
        bus_wr(BASE + 32'h0C, 32'h1D);
        repeat (600) @(negedge clk);
        count_high(256, c0, c1, c2);
        check("pwm192_window", 32'(c0), 32'd192);
        check("inv_duty0", 32'(c1), 32'd256);
        check("pwm_duty255", 32'(c2), 32'd255);

        // Asynchronous reset in the middle of a PWM period
        async_pulse(1'b1);
        for (int o = 0; o < 16; o++) rd_chk(BASE + 32'(4 * o), 32'h0, "post_rst_read");
        repeat (300) @(negedge clk);
        check("led_hold_after_rst", 32'(led), 32'h0);

        // Blink: PRESC=3 and BLINK=1 give a 2048-cycle half-period
        bus_wr(BASE + 32'h04, 32'd3);
        bus_wr(BASE + 32'h10, 32'd1);
        bus_wr(BASE + 32'h08, 32'h01);
        bus_wr(BASE + 32'h0C, 32'h2);
        bus_wr(BASE + 32'h00, 32'h1);
        wait_level(0, 1'b0, 20, "blink_start_low");
        wait_level(0, 1'b1, 3000, "blink_first_high");
        run_len(0, 1'b1, n);
        check("blink_high_len", 32'(n), 32'd2048);
        wait_level(0, 1'b1, 3000, "blink_second_high");
        repeat (500) @(negedge clk);
        we = 1'b1; a = BASE; wd = 32'h3;
        @(negedge clk);
        we = 1'b0;
        wait_level(0, 1'b0, 10, "prst_forces_low");
        run_len(0, 1'b0, n);
        check("prst_low_len", 32'(n), 32'd2048);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
